// File: rtl/eth_40gb_tx_lane_gearbox.sv
// One 40GBASE-R transmit lane: scrambles 66b block payloads (x^58+x^39+1) and gears the
// 66-bit blocks down to 32-bit transceiver words, inserting idle blocks when upstream stalls.
module eth_40gb_tx_lane_gearbox #(
  parameter bit          SCRAMBLE_EN = 1'b1,
  parameter logic [57:0] SCR_SEED    = {58{1'b1}}
) (
  input  logic        core_clk,
  input  logic        core_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_header,
  input  logic [63:0] in_payload,
  output logic [31:0] tx_data,
  output logic [15:0] idle_ins_cnt
);

  localparam logic [63:0] IdlePayload = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  CtrlHeader  = 2'b10;

  logic [97:0] buf_q, buf_d, buf_post;
  logic [6:0]  cnt_q, cnt_d;
  logic [57:0] scr_q, scr_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  logic         load;
  logic [1:0]   blk_hdr;
  logic [63:0]  blk_pay;
  logic [121:0] scr_res;
  logic [65:0]  blk;

  // Serial-equivalent scrambler: bit 0 first, each output bit fed back into the state.
  function automatic logic [121:0] scramble(input logic [57:0] seed, input logic [63:0] d);
    logic [57:0] s;
    logic [63:0] o;
    s = seed;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ s[38] ^ s[57];
      s    = {s[56:0], o[i]};
    end
    return {s, o};
  endfunction

  assign load     = (cnt_q < 7'd32);
  assign in_ready = load;

  always_comb begin
    blk_hdr = in_valid ? in_header  : CtrlHeader;
    blk_pay = in_valid ? in_payload : IdlePayload;
    scr_res = SCRAMBLE_EN ? scramble(scr_q, blk_pay) : {scr_q, blk_pay};
    blk     = {scr_res[63:0], blk_hdr};
    scr_d   = load ? scr_res[121:64] : scr_q;

    // Bits at and above cnt are always zero, so the new block can be ORed in place.
    buf_post  = load ? (buf_q | ({32'd0, blk} << cnt_q)) : buf_q;
    tx_data_d = buf_post[31:0];
    buf_d     = {32'd0, buf_post[97:32]};
    cnt_d     = cnt_q + (load ? 7'd66 : 7'd0) - 7'd32;

    idle_cnt_d = idle_cnt_q;
    if (load && !in_valid && (idle_cnt_q != 16'hFFFF)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      scr_q      <= SCR_SEED;
      tx_data_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      scr_q      <= scr_d;
      tx_data_q  <= tx_data_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign idle_ins_cnt = idle_cnt_q;

endmodule

// File: tb/tb_eth_40gb_tx_lane_gearbox.sv
// Bench for eth_40gb_tx_lane_gearbox: bit-queue model of the lane stream plus a
// self-synchronous descrambler that recovers blocks from the serialised tx_data.
module tb_eth_40gb_tx_lane_gearbox;

  logic        core_clk    = 1'b0;
  logic        core_resetn = 1'b0;
  logic        in_valid    = 1'b0;
  logic [1:0]  in_header   = 2'b00;
  logic [63:0] in_payload  = 64'd0;
  logic        in_ready, in_ready_raw;
  logic [31:0] tx_data, tx_data_raw;
  logic [15:0] idle_ins_cnt, idle_raw;

  int total = 0;
  int bad   = 0;

  bit          q_s[$];     // expected scrambled bit stream, oldest first
  bit          q_u[$];     // expected unscrambled bit stream
  bit          hist[$];    // last 58 scrambler outputs, newest at the back
  bit          rx_bits[$]; // serialised tx_data of the scrambling instance
  logic [65:0] sent[$];    // blocks loaded, {payload, header}, plain payload
  logic [65:0] dec[$];     // blocks recovered by the descrambler
  int          hs_cnt;
  logic [15:0] idle_exp;

  always #5 core_clk = ~core_clk;

  eth_40gb_tx_lane_gearbox dut (
    .core_clk    (core_clk),
    .core_resetn (core_resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_header   (in_header),
    .in_payload  (in_payload),
    .tx_data     (tx_data),
    .idle_ins_cnt(idle_ins_cnt)
  );

  eth_40gb_tx_lane_gearbox #(.SCRAMBLE_EN(1'b0)) dut_raw (
    .core_clk    (core_clk),
    .core_resetn (core_resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready_raw),
    .in_header   (in_header),
    .in_payload  (in_payload),
    .tx_data     (tx_data_raw),
    .idle_ins_cnt(idle_raw)
  );

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_s.delete();
    q_u.delete();
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    rx_bits.delete();
    sent.delete();
    hs_cnt   = 0;
    idle_exp = 16'd0;
  endtask

  task automatic do_reset(input int n);
    @(negedge core_clk);
    core_resetn = 1'b0;
    in_valid    = 1'b0;
    #1;
    check("rst_tx", tx_data, 66'd0);
    check("rst_tx_raw", tx_data_raw, 66'd0);
    check("rst_ready", in_ready, 66'd1);
    check("rst_idle", idle_ins_cnt, 66'd0);
    repeat (n) @(negedge core_clk);
    check("rst_hold_tx", tx_data, 66'd0);
    check("rst_hold_ready", in_ready, 66'd1);
    core_resetn = 1'b1;
    model_reset();
  endtask

  // One clock: starts and ends at a negedge; model predicts ready, stream and idle count.
  task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] p,
                       output logic loaded);
    logic [1:0]  hb;
    logic [63:0] pb;
    logic [31:0] es, eu;
    logic        o, exp_rdy;
    in_valid   = v;
    in_header  = h;
    in_payload = p;
    exp_rdy = (q_s.size() < 32);
    check("in_ready", in_ready, exp_rdy);
    check("in_ready_raw", in_ready_raw, exp_rdy);
    loaded = exp_rdy;
    if (exp_rdy) begin
      hb = v ? h : 2'b10;
      pb = v ? p : 64'h1E;
      sent.push_back({pb, hb});
      for (int i = 0; i < 2; i++) begin
        q_s.push_back(hb[i]);
        q_u.push_back(hb[i]);
      end
      for (int i = 0; i < 64; i++) begin
        o = pb[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
        hist.push_back(o);
        void'(hist.pop_front());
        q_s.push_back(o);
        q_u.push_back(pb[i]);
      end
      if (v) hs_cnt++;
      else if (idle_exp != 16'hFFFF) idle_exp++;
    end
    for (int i = 0; i < 32; i++) begin
      es[i] = q_s.pop_front();
      eu[i] = q_u.pop_front();
    end
    @(posedge core_clk);
    #1;
    check("tx_data", tx_data, es);
    check("tx_data_raw", tx_data_raw, eu);
    check("idle_cnt", idle_ins_cnt, idle_exp);
    check("idle_cnt_raw", idle_raw, idle_exp);
    for (int i = 0; i < 32; i++) rx_bits.push_back(tx_data[i]);
    @(negedge core_clk);
  endtask

  // Block alignment is known from reset; descrambler starts with an unknown (zero) state.
  task automatic descramble();
    logic [57:0] ds;
    logic [65:0] b;
    bit          r;
    int          nb;
    ds = '0;
    dec.delete();
    nb = rx_bits.size() / 66;
    for (int k = 0; k < nb; k++) begin
      b[0] = rx_bits[66 * k];
      b[1] = rx_bits[66 * k + 1];
      for (int i = 0; i < 64; i++) begin
        r        = rx_bits[66 * k + 2 + i];
        b[2 + i] = r ^ ds[38] ^ ds[57];
        ds       = {ds[56:0], r};
      end
      dec.push_back(b);
    end
  endtask

  task automatic check_blocks(input string name);
    int n;
    descramble();
    n = (dec.size() < sent.size()) ? dec.size() : sent.size();
    check({name, "_nblk_enough"}, 66'(n > 20), 66'd1);
    for (int b = 1; b < n; b++) check(name, dec[b], sent[b]);
  endtask

  initial begin
    logic        ld, cur_v, took;
    logic [1:0]  cur_h;
    logic [63:0] cur_p;
    int          loads, pat_bad, hs_seen;
    bit          rdy_hist[$];

    // Reset and literal word pins (raw instance: unscrambled; dut: all-ones seed).
    do_reset(5);
    cycle(1'b1, 2'b01, 64'h0, ld);
    check("t2_w0_raw", tx_data_raw, 66'h0000_0001);
    check("t2_w0_scr", tx_data, 66'h0000_0001);
    cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, ld);
    check("t2_w1_raw", tx_data_raw, 66'h0000_0000);
    check("t2_w1_scr", tx_data, 66'h0FFF_FE00);
    cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, ld);
    check("t2_w2_raw", tx_data_raw, 66'hFFFF_FFF8);
    for (int k = 0; k < 20; k++) cycle(1'b1, 2'b01, {$urandom, $urandom}, ld);

    // Reset mid-traffic; the model restarts at cnt = 0 and keeps checking.
    do_reset(1);
    for (int k = 0; k < 10; k++) cycle(1'b1, 2'b10, {$urandom, $urandom}, ld);

    // Continuous valid: 160 handshakes in 330 cycles, ready pattern repeats every 33.
    do_reset(2);
    hs_seen = 0;
    rdy_hist.delete();
    for (int k = 0; k < 330; k++) begin
      rdy_hist.push_back(in_ready);
      if (in_ready) hs_seen++;
      cycle(1'b1, 2'b01, {$urandom, $urandom}, ld);
    end
    check("t3_handshakes", hs_seen, 66'd160);
    check("t3_model_hs", hs_cnt, 66'd160);
    pat_bad = 0;
    for (int k = 0; k + 33 < 330; k++) if (rdy_hist[k] != rdy_hist[k + 33]) pat_bad++;
    check("t3_ready_period", pat_bad, 66'd0);

    // Underflow: 10 load slots with in_valid low insert 10 idle blocks.
    do_reset(2);
    loads = 0;
    while (loads < 10) begin
      cycle(1'b0, 2'b01, 64'hDEAD_BEEF_0000_1234, ld);
      if (ld) loads++;
    end
    check("t4_idle_cnt", idle_ins_cnt, 66'd10);
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'b01, 64'h0, ld);
    descramble();
    check("t4_dec_size", 66'(dec.size() >= 10), 66'd1);
    for (int b = 1; b < 10 && b < dec.size(); b++)
      check("t4_idle_block", dec[b], {64'h1E, 2'b10});

    // Random blocks, valid always high, then descramble the serial stream.
    do_reset(2);
    cur_h = 2'b01;
    cur_p = {$urandom, $urandom};
    for (int k = 0; k < 200; k++) begin
      cycle(1'b1, cur_h, cur_p, ld);
      if (ld) begin
        cur_h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        cur_p = {$urandom, $urandom};
      end
    end
    check_blocks("t5_block");

    // Random stalls: data held until handshake, idles fill the gaps.
    do_reset(2);
    cur_v = 1'b0;
    took  = 1'b1;
    cur_h = 2'b01;
    cur_p = 64'd0;
    for (int k = 0; k < 300; k++) begin
      if (!cur_v || took) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        cur_p = {$urandom, $urandom};
      end
      cycle(cur_v, cur_h, cur_p, ld);
      took = ld && cur_v;
    end
    check_blocks("t6_block");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
